// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, divisor config struct and default-divisor helper
package uart_pkg;
  localparam int OSR_MIN = 4;
  localparam int OSR_MAX = 32;
  localparam int CFG_DIV_W = 16;
  localparam int CFG_FRAC_W = 4;
  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic [CFG_FRAC_W-1:0] frac;
  } baud_cfg_t;
  // Divisor giving the closest tick rate: period = div+1 cycles per oversample tick
  function automatic int calc_div(longint freq, longint baud, int osr);
    longint d;
    d = baud * osr;
    return int'((freq + d / 2) / d - 1);
  endfunction
endpackage

// File: rtl/uart_frac_acc.sv
// uart_frac_acc: fractional divisor accumulator producing a period-stretch carry
// Ports: i_clk, i_rst (sync, active high), i_clr holds the accumulator at zero,
// i_step adds i_frac once per terminal count, o_carry stretches the next period by one cycle.
module uart_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_step,
  input  logic [FRAC_W-1:0] i_frac,
  output logic              o_carry
);
  logic [FRAC_W-1:0] acc;
  always_ff @(posedge i_clk)
    if (i_rst || i_clr) {o_carry, acc} <= '0;
    else if (i_step) {o_carry, acc} <= {1'b0, acc} + {1'b0, i_frac};
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample and baud tick generator with double-buffered divisor
// Ports: i_clk, i_rst (sync, active high), i_en run enable, i_cfg_we/i_cfg_div/i_cfg_frac
// shadow divisor write, o_stick oversample tick, o_btick baud tick, o_phase oversample
// phase, o_cfg_pending shadow not yet active.
// Build option: UART_BAUD_FRAC_EN adds the fractional divisor; without it the period is div+1.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int FRAC_W = 4,
  parameter int OSR = 16,
  parameter int RST_DIV = 325,
  parameter int RST_FRAC = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_cfg_we,
  input  logic [DIV_W-1:0]        i_cfg_div,
  input  logic [FRAC_W-1:0]       i_cfg_frac,
  output logic                    o_stick,
  output logic                    o_btick,
  output logic [$clog2(OSR)-1:0]  o_phase,
  output logic                    o_cfg_pending
);
  localparam int PW = $clog2(OSR);
  localparam int OSR_EFF = OSR < OSR_MIN ? OSR_MIN : OSR > OSR_MAX ? OSR_MAX : OSR;
  localparam logic [PW-1:0] LAST = PW'(OSR_EFF - 1);
  logic [DIV_W-1:0] act_div, shd_div;
  // One spare bit so div+carry never wraps at the maximum divisor
  logic [DIV_W:0] cnt;
  logic [PW-1:0] phase;
  logic carry, term, stick, btick, pending;
  assign term = i_en && (cnt == {1'b0, act_div} + (DIV_W+1)'(carry));
`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] act_frac, shd_frac;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      act_frac <= FRAC_W'(RST_FRAC);
      shd_frac <= FRAC_W'(RST_FRAC);
    end else begin
      if (!i_en || term) act_frac <= shd_frac;
      if (i_cfg_we) shd_frac <= i_cfg_frac;
    end
  uart_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (!i_en),
    .i_step (term),
    .i_frac (act_frac),
    .o_carry(carry)
  );
`else
  logic [FRAC_W-1:0] unused_frac;
  assign unused_frac = i_cfg_frac ^ FRAC_W'(RST_FRAC);
  assign carry = 1'b0;
`endif
  always_ff @(posedge i_clk)
    if (i_rst) begin
      cnt <= '0;
      phase <= '0;
      stick <= 1'b0;
      btick <= 1'b0;
      pending <= 1'b0;
      act_div <= DIV_W'(RST_DIV);
      shd_div <= DIV_W'(RST_DIV);
    end else begin
      stick <= term;
      btick <= term && phase == LAST;
      cnt <= (!i_en || term) ? '0 : cnt + (DIV_W+1)'(1);
      if (!i_en) phase <= '0;
      else if (term) phase <= (phase == LAST) ? '0 : phase + 1'b1;
      // Transfer reads the pre-write shadow, so a coincident write waits one more terminal count
      if (!i_en || term) act_div <= shd_div;
      if (i_cfg_we) shd_div <= i_cfg_div;
      pending <= i_cfg_we || (pending && i_en && !term);
    end
  assign o_stick = stick;
  assign o_btick = btick;
  assign o_phase = phase;
  assign o_cfg_pending = pending;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: randomized scoreboard bench for uart_baud_gen against a period-level model
module tb_uart_baud_gen;
  localparam int OSR = 16;
  localparam int RDIV = 325;
  logic clk = 1'b0, rst, en, we;
  logic [15:0] cfg_div;
  logic [3:0] cfg_frac;
  logic stick, btick, pending;
  logic [3:0] phase;

  uart_baud_gen dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_cfg_we(we), .i_cfg_div(cfg_div),
    .i_cfg_frac(cfg_frac), .o_stick(stick), .o_btick(btick), .o_phase(phase),
    .o_cfg_pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {int e; int ph; bit bt;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, edge_n = 0;
  bit started = 0;
  // Model: each period starts at edge m_ps and lasts m_len edges; the stick is seen after its last edge
  int m_act, m_shd, m_actf, m_shdf, m_acc, m_phase, m_ps, m_len;
  bit m_pend, m_carry, m_run;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
    end
  endtask

  task automatic model(bit r, bit e, bit w, int d, int f);
    int s;
    if (r) begin
      m_act = RDIV; m_shd = RDIV; m_actf = 0; m_shdf = 0; m_acc = 0; m_carry = 0;
      m_phase = 0; m_pend = 0; m_run = 0;
      q.delete();
      return;
    end
    if (!e) begin
      m_run = 0; m_phase = 0; m_acc = 0; m_carry = 0;
      m_act = m_shd; m_actf = m_shdf; m_pend = w;
    end else begin
      if (!m_run) begin
        m_run = 1; m_ps = edge_n; m_len = m_act + 1 + m_carry;
      end
      if (edge_n == m_ps + m_len - 1) begin
        q.push_back(exp_t'{edge_n, (m_phase + 1) % OSR, m_phase == OSR - 1});
        m_phase = (m_phase + 1) % OSR;
`ifdef UART_BAUD_FRAC_EN
        s = m_acc + m_actf;
        m_carry = s >= 16;
        m_acc = s % 16;
`else
        s = 0;
`endif
        m_act = m_shd; m_actf = m_shdf; m_pend = w;
        m_ps = edge_n + 1; m_len = m_act + 1 + m_carry;
      end else if (w) m_pend = 1;
    end
    if (w) begin
      m_shd = d; m_shdf = f;
    end
  endtask

  task automatic step(bit r, bit e, bit w, int d, int f);
    #1;
    rst = r; en = e; we = w; cfg_div = 16'(d); cfg_frac = 4'(f);
    @(posedge clk);
    edge_n++;
    model(r, e, w, d, f);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0);
  endtask

  // Advance until the next edge is a terminal count, then write there
  task automatic write_on_term(int d, int f);
    int i;
    for (i = 0; i < 400 && !(m_run && edge_n + 1 == m_ps + m_len - 1); i++) step(0, 1, 0, 0, 0);
    if (i == 400) chk("term_wait", 0, 1);
    step(0, 1, 1, d, f);
  endtask

  always @(negedge clk) begin
    bit es;
    exp_t x;
    if (started) begin
      es = q.size() > 0 && q[0].e == edge_n;
      x = exp_t'{0, 0, 0};
      if (es) x = q.pop_front();
      chk("stick", int'(stick), int'(es));
      chk("btick", int'(btick), int'(es && x.bt));
      chk("phase", int'(phase), m_phase);
      chk("pending", int'(pending), int'(m_pend));
      if (es) chk("stick_phase", int'(phase), x.ph);
    end
  end

  initial begin
    rst = 1; en = 0; we = 0; cfg_div = 0; cfg_frac = 0;
    step(1, 0, 0, 0, 0);
    started = 1;
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0);
    run(140);
    step(0, 1, 1, 3, 8);
    run(160);
    step(0, 1, 1, 0, 0);
    run(40);
    step(0, 1, 1, 3, 0);
    run(10);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 9, 0);
    run(50);
    step(0, 1, 1, 7, 0);
    write_on_term(2, 0);
    run(40);
    step(0, 1, 1, 3, 5);
    write_on_term(1, 3);
    write_on_term(4, 9);
    run(60);
    step(0, 1, 1, 5, 0);
    run(8);
    step(0, 0, 0, 0, 0);
    run(30);
    step(1, 1, 1, 2, 2);
    run(700);
    step(0, 1, 1, 6, 0);
    run(3);
    step(0, 1, 1, 2, 0);
    run(30);
    for (int i = 0; i < 3500; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 29) != 0, $urandom_range(0, 11) == 0,
           int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
    run(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
